// File: rtl/global_defs.sv
// Shared memory-interface types for the KNN datapath, plus the ownership
// types used by the memory port scheduler.
//   ADDR / MEM_BLOCK / MEM_TAG / MEM_COMMAND : memory bus types
//   req_owner_e / tag_entry_t                : tag-owner table entries
//   grant_e                                  : scheduler grant selection
package global_defs;

  typedef logic [31:0] ADDR;
  typedef logic [63:0] MEM_BLOCK;
  typedef logic [3:0]  MEM_TAG;

  typedef enum logic [1:0] {
    MEM_NONE  = 2'h0,
    MEM_LOAD  = 2'h1,
    MEM_STORE = 2'h2
  } MEM_COMMAND;

  typedef enum logic {
    OWN_Q = 1'b0,
    OWN_R = 1'b1
  } req_owner_e;

  typedef struct packed {
    logic       valid;
    req_owner_e owner;
  } tag_entry_t;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_W    = 2'd1,
    GNT_Q    = 2'd2,
    GNT_R    = 2'd3
  } grant_e;

endpackage

// File: rtl/mem_port_scheduler_if.sv
// Requester-side bundle of the memory port scheduler.
//   q_* : query load request / response
//   r_* : reference load request / response
//   w_* : writeback store request
// master = requester (KNN memory controller), slave = scheduler.
interface mem_port_scheduler_if;
  import global_defs::*;

  logic     q_req_valid;
  ADDR      q_req_addr;
  logic     q_req_ready;
  logic     q_rsp_valid;
  MEM_BLOCK q_rsp_data;

  logic     r_req_valid;
  ADDR      r_req_addr;
  logic     r_req_ready;
  logic     r_rsp_valid;
  MEM_BLOCK r_rsp_data;

  logic     w_req_valid;
  ADDR      w_req_addr;
  MEM_BLOCK w_req_data;
  logic     w_req_ready;

  modport master (
    output q_req_valid, q_req_addr,
    input  q_req_ready, q_rsp_valid, q_rsp_data,
    output r_req_valid, r_req_addr,
    input  r_req_ready, r_rsp_valid, r_rsp_data,
    output w_req_valid, w_req_addr, w_req_data,
    input  w_req_ready
  );

  modport slave (
    input  q_req_valid, q_req_addr,
    output q_req_ready, q_rsp_valid, q_rsp_data,
    input  r_req_valid, r_req_addr,
    output r_req_ready, r_rsp_valid, r_rsp_data,
    input  w_req_valid, w_req_addr, w_req_data,
    output w_req_ready
  );

endinterface

// File: rtl/mem_tag_table.sv
// Tag-owner table: one entry per memory tag recording which load requester
// owns an in-flight load.
//   alloc_en/alloc_tag/alloc_owner : record a newly accepted load
//   ret_tag                        : tag of returning data (0 = none)
//   ret_hit/ret_owner              : returning tag is owned; entry is freed
//   ret_stray                      : returning tag has no owner
//   alloc_reuse/reuse_owner        : allocation hits a still-live entry
// A return and an allocation of the same tag in one cycle free first and
// then allocate, so that case is not a reuse.
module mem_tag_table
  import global_defs::*;
#(
  parameter int NUM_TAGS = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       alloc_en,
  input  MEM_TAG     alloc_tag,
  input  req_owner_e alloc_owner,
  input  MEM_TAG     ret_tag,
  output logic       ret_hit,
  output req_owner_e ret_owner,
  output logic       ret_stray,
  output logic       alloc_reuse,
  output req_owner_e reuse_owner
);

  tag_entry_t tag_tbl [NUM_TAGS];
  tag_entry_t ret_entry;
  tag_entry_t alloc_entry;

  assign ret_entry   = tag_tbl[ret_tag];
  assign alloc_entry = tag_tbl[alloc_tag];

  assign ret_hit     = (ret_tag != '0) && ret_entry.valid;
  assign ret_stray   = (ret_tag != '0) && !ret_entry.valid;
  assign ret_owner   = ret_entry.owner;

  assign alloc_reuse = alloc_en && alloc_entry.valid &&
                       !(ret_hit && (ret_tag == alloc_tag));
  assign reuse_owner = alloc_entry.owner;

  // The allocation write comes after the free so it wins on a shared tag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_TAGS; i++) tag_tbl[i] <= '0;
    end else begin
      if (ret_hit) tag_tbl[ret_tag].valid <= 1'b0;
      if (alloc_en) tag_tbl[alloc_tag] <= '{valid: 1'b1, owner: alloc_owner};
    end
  end

endmodule

// File: rtl/mem_port_scheduler.sv
// Shares the single memory port between query loads (Q), reference loads (R)
// and result writeback stores (W). Fixed priority W > Q > R, at most one
// command per cycle; load tags are tracked so returned data reaches its owner.
//   clk, rst (async, active low)
//   req                      : requester bundle (slave side)
//   mem2proc_transaction_tag : acceptance tag for this cycle's command, 0 = rejected
//   mem2proc_data/_data_tag  : load return, tag 0 = none
//   proc2mem_command/addr/data : command to memory
//   idle                     : no loads outstanding and no request pending
//   err_stray_tag            : sticky, a return carried an unowned tag
//   err_tag_reuse            : sticky, an accepted load reused a live tag
// MAX_OUTSTANDING must stay at or below 15.
module mem_port_scheduler
  import global_defs::*;
#(
  parameter int MAX_OUTSTANDING = 8,
  parameter int NUM_TAGS        = 16
) (
  input  logic       clk,
  input  logic       rst,
  mem_port_scheduler_if.slave req,
  input  MEM_TAG     mem2proc_transaction_tag,
  input  MEM_BLOCK   mem2proc_data,
  input  MEM_TAG     mem2proc_data_tag,
  output MEM_COMMAND proc2mem_command,
  output ADDR        proc2mem_addr,
  output MEM_BLOCK   proc2mem_data,
  output logic       idle,
  output logic       err_stray_tag,
  output logic       err_tag_reuse
);

  localparam int CW = $clog2(MAX_OUTSTANDING + 1);

  logic [CW-1:0] q_cnt, r_cnt;
  logic          q_elig, r_elig;
  grant_e        grant;
  logic          tag_ok;
  logic          alloc_en;
  req_owner_e    alloc_owner;
  logic          ret_hit, ret_stray, alloc_reuse;
  req_owner_e    ret_owner, reuse_owner;
  logic          q_dec_ret, r_dec_ret, q_dec_reuse, r_dec_reuse;

  assign q_elig = req.q_req_valid && (q_cnt < CW'(MAX_OUTSTANDING));
  assign r_elig = req.r_req_valid && (r_cnt < CW'(MAX_OUTSTANDING));

  always_comb begin
    grant            = GNT_NONE;
    proc2mem_command = MEM_NONE;
    proc2mem_addr    = '0;
    proc2mem_data    = '0;
    if (req.w_req_valid) begin
      grant            = GNT_W;
      proc2mem_command = MEM_STORE;
      proc2mem_addr    = req.w_req_addr;
      proc2mem_data    = req.w_req_data;
    end else if (q_elig) begin
      grant            = GNT_Q;
      proc2mem_command = MEM_LOAD;
      proc2mem_addr    = req.q_req_addr;
    end else if (r_elig) begin
      grant            = GNT_R;
      proc2mem_command = MEM_LOAD;
      proc2mem_addr    = req.r_req_addr;
    end
  end

  assign tag_ok          = (mem2proc_transaction_tag != '0);
  assign req.w_req_ready = (grant == GNT_W) && tag_ok;
  assign req.q_req_ready = (grant == GNT_Q) && tag_ok;
  assign req.r_req_ready = (grant == GNT_R) && tag_ok;

  assign alloc_en    = req.q_req_ready || req.r_req_ready;
  assign alloc_owner = req.r_req_ready ? OWN_R : OWN_Q;

  mem_tag_table #(
    .NUM_TAGS (NUM_TAGS)
  ) u_tag_table (
    .clk         (clk),
    .rst         (rst),
    .alloc_en    (alloc_en),
    .alloc_tag   (mem2proc_transaction_tag),
    .alloc_owner (alloc_owner),
    .ret_tag     (mem2proc_data_tag),
    .ret_hit     (ret_hit),
    .ret_owner   (ret_owner),
    .ret_stray   (ret_stray),
    .alloc_reuse (alloc_reuse),
    .reuse_owner (reuse_owner)
  );

  assign q_dec_ret   = ret_hit && (ret_owner == OWN_Q);
  assign r_dec_ret   = ret_hit && (ret_owner == OWN_R);
  assign q_dec_reuse = alloc_reuse && (reuse_owner == OWN_Q);
  assign r_dec_reuse = alloc_reuse && (reuse_owner == OWN_R);

  // A requester can gain one and lose up to two loads in the same cycle
  // (an accept, a return, and an overwritten live tag).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_cnt <= '0;
      r_cnt <= '0;
    end else begin
      q_cnt <= q_cnt + CW'(req.q_req_ready) - CW'(q_dec_ret) - CW'(q_dec_reuse);
      r_cnt <= r_cnt + CW'(req.r_req_ready) - CW'(r_dec_ret) - CW'(r_dec_reuse);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req.q_rsp_valid <= 1'b0;
      req.q_rsp_data  <= '0;
      req.r_rsp_valid <= 1'b0;
      req.r_rsp_data  <= '0;
      err_stray_tag   <= 1'b0;
      err_tag_reuse   <= 1'b0;
    end else begin
      req.q_rsp_valid <= q_dec_ret;
      req.r_rsp_valid <= r_dec_ret;
      if (q_dec_ret) req.q_rsp_data <= mem2proc_data;
      if (r_dec_ret) req.r_rsp_data <= mem2proc_data;
      err_stray_tag   <= err_stray_tag | ret_stray;
      err_tag_reuse   <= err_tag_reuse | alloc_reuse;
    end
  end

  assign idle = (q_cnt == '0) && (r_cnt == '0) &&
                !req.q_req_valid && !req.r_req_valid && !req.w_req_valid;

endmodule

// File: tb/tb_mem_port_scheduler.sv
module tb_mem_port_scheduler;
  import global_defs::*;

  logic       clk;
  logic       rst;
  MEM_TAG     mem2proc_transaction_tag;
  MEM_BLOCK   mem2proc_data;
  MEM_TAG     mem2proc_data_tag;
  MEM_COMMAND proc2mem_command;
  ADDR        proc2mem_addr;
  MEM_BLOCK   proc2mem_data;
  logic       idle;
  logic       err_stray_tag;
  logic       err_tag_reuse;

  int n_cmp;
  int n_bad;

  mem_port_scheduler_if bus ();

  mem_port_scheduler #(
    .MAX_OUTSTANDING (8),
    .NUM_TAGS        (16)
  ) dut (
    .clk                      (clk),
    .rst                      (rst),
    .req                      (bus),
    .mem2proc_transaction_tag (mem2proc_transaction_tag),
    .mem2proc_data            (mem2proc_data),
    .mem2proc_data_tag        (mem2proc_data_tag),
    .proc2mem_command         (proc2mem_command),
    .proc2mem_addr            (proc2mem_addr),
    .proc2mem_data            (proc2mem_data),
    .idle                     (idle),
    .err_stray_tag            (err_stray_tag),
    .err_tag_reuse            (err_tag_reuse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic clear_inputs();
    bus.q_req_valid = 1'b0;
    bus.q_req_addr  = '0;
    bus.r_req_valid = 1'b0;
    bus.r_req_addr  = '0;
    bus.w_req_valid = 1'b0;
    bus.w_req_addr  = '0;
    bus.w_req_data  = '0;
    mem2proc_transaction_tag = '0;
    mem2proc_data            = '0;
    mem2proc_data_tag        = '0;
  endtask

  // Inputs change 1 unit after the rising edge, checks happen 1 unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b0;
    #1;
    check("rst_q_rsp_valid", 64'(bus.q_rsp_valid), 64'd0);
    check("rst_r_rsp_data", bus.r_rsp_data, 64'd0);
    check("rst_err_stray", 64'(err_stray_tag), 64'd0);
    check("rst_idle", 64'(idle), 64'd1);
    rst = 1'b1;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    clear_inputs();
    rst = 1'b0;
    #12;
    check("reset_cmd", 64'(proc2mem_command), 64'(MEM_NONE));
    check("reset_addr", 64'(proc2mem_addr), 64'd0);
    check("reset_data", proc2mem_data, 64'd0);
    check("reset_idle", 64'(idle), 64'd1);
    check("reset_q_rsp_valid", 64'(bus.q_rsp_valid), 64'd0);
    check("reset_q_rsp_data", bus.q_rsp_data, 64'd0);
    check("reset_err_stray", 64'(err_stray_tag), 64'd0);
    check("reset_err_reuse", 64'(err_tag_reuse), 64'd0);
    rst = 1'b1;

    // Single Q load, tag 3, data returns two cycles after issue.
    tick();
    bus.q_req_valid = 1'b1;
    bus.q_req_addr  = 32'h1000;
    mem2proc_transaction_tag = 4'd3;
    settle();
    check("t1_q_ready", 64'(bus.q_req_ready), 64'd1);
    check("t1_cmd", 64'(proc2mem_command), 64'(MEM_LOAD));
    check("t1_addr", 64'(proc2mem_addr), 64'h1000);
    tick();
    clear_inputs();
    settle();
    check("t1_not_idle", 64'(idle), 64'd0);
    check("t1_cmd_none", 64'(proc2mem_command), 64'(MEM_NONE));
    tick();
    mem2proc_data_tag = 4'd3;
    mem2proc_data     = 64'hDEAD;
    settle();
    check("t1_no_early_rsp", 64'(bus.q_rsp_valid), 64'd0);
    tick();
    clear_inputs();
    settle();
    check("t1_q_rsp_valid", 64'(bus.q_rsp_valid), 64'd1);
    check("t1_q_rsp_data", bus.q_rsp_data, 64'hDEAD);
    check("t1_r_rsp_quiet", 64'(bus.r_rsp_valid), 64'd0);
    check("t1_idle", 64'(idle), 64'd1);
    tick();
    settle();
    check("t1_pulse_end", 64'(bus.q_rsp_valid), 64'd0);

    // W, Q, R simultaneously: STORE, LOAD Q, LOAD R with tags 1, 2, 3.
    bus.w_req_valid = 1'b1;
    bus.w_req_addr  = 32'h2000;
    bus.w_req_data  = 64'h1111;
    bus.q_req_valid = 1'b1;
    bus.q_req_addr  = 32'h3000;
    bus.r_req_valid = 1'b1;
    bus.r_req_addr  = 32'h4000;
    mem2proc_transaction_tag = 4'd1;
    settle();
    check("t2_cmd_store", 64'(proc2mem_command), 64'(MEM_STORE));
    check("t2_store_addr", 64'(proc2mem_addr), 64'h2000);
    check("t2_store_data", proc2mem_data, 64'h1111);
    check("t2_w_ready", 64'(bus.w_req_ready), 64'd1);
    check("t2_q_ready_blocked", 64'(bus.q_req_ready), 64'd0);
    check("t2_r_ready_blocked", 64'(bus.r_req_ready), 64'd0);
    tick();
    bus.w_req_valid = 1'b0;
    mem2proc_transaction_tag = 4'd2;
    settle();
    check("t2_cmd_q", 64'(proc2mem_command), 64'(MEM_LOAD));
    check("t2_q_addr", 64'(proc2mem_addr), 64'h3000);
    check("t2_q_ready", 64'(bus.q_req_ready), 64'd1);
    check("t2_q_data_zero", proc2mem_data, 64'd0);
    tick();
    bus.q_req_valid = 1'b0;
    mem2proc_transaction_tag = 4'd3;
    settle();
    check("t2_cmd_r", 64'(proc2mem_command), 64'(MEM_LOAD));
    check("t2_r_addr", 64'(proc2mem_addr), 64'h4000);
    check("t2_r_ready", 64'(bus.r_req_ready), 64'd1);
    tick();
    clear_inputs();
    mem2proc_data_tag = 4'd2;
    mem2proc_data     = 64'hA2;
    tick();
    mem2proc_data_tag = 4'd3;
    mem2proc_data     = 64'hA3;
    settle();
    check("t2_q_rsp_valid", 64'(bus.q_rsp_valid), 64'd1);
    check("t2_q_rsp_data", bus.q_rsp_data, 64'hA2);
    tick();
    clear_inputs();
    settle();
    check("t2_r_rsp_valid", 64'(bus.r_rsp_valid), 64'd1);
    check("t2_r_rsp_data", bus.r_rsp_data, 64'hA3);
    check("t2_q_rsp_done", 64'(bus.q_rsp_valid), 64'd0);
    check("t2_idle", 64'(idle), 64'd1);

    // R request rejected three times, accepted on the fourth cycle.
    tick();
    bus.r_req_valid = 1'b1;
    bus.r_req_addr  = 32'h5000;
    for (int i = 0; i < 3; i++) begin
      settle();
      check("t3_reject_ready", 64'(bus.r_req_ready), 64'd0);
      check("t3_held_addr", 64'(proc2mem_addr), 64'h5000);
      tick();
    end
    mem2proc_transaction_tag = 4'd1;
    settle();
    check("t3_accept_ready", 64'(bus.r_req_ready), 64'd1);
    tick();
    clear_inputs();
    settle();
    check("t3_r_cnt", 64'(dut.r_cnt), 64'd1);
    tick();
    mem2proc_data_tag = 4'd1;
    mem2proc_data     = 64'h51;
    tick();
    clear_inputs();
    settle();
    check("t3_r_rsp_data", bus.r_rsp_data, 64'h51);

    // Eight R loads fill R; Q still granted; a return reopens R.
    for (int i = 0; i < 8; i++) begin
      tick();
      bus.r_req_valid = 1'b1;
      bus.r_req_addr  = 32'h6000 + 32'(i) * 32'h40;
      mem2proc_transaction_tag = 4'(i + 1);
      settle();
      check("t4_fill_ready", 64'(bus.r_req_ready), 64'd1);
    end
    tick();
    bus.r_req_addr  = 32'h6200;
    bus.q_req_valid = 1'b1;
    bus.q_req_addr  = 32'h7000;
    mem2proc_transaction_tag = 4'd9;
    settle();
    check("t4_q_granted_addr", 64'(proc2mem_addr), 64'h7000);
    check("t4_q_ready", 64'(bus.q_req_ready), 64'd1);
    check("t4_r_blocked_q", 64'(bus.r_req_ready), 64'd0);
    tick();
    bus.q_req_valid = 1'b0;
    mem2proc_transaction_tag = 4'd10;
    mem2proc_data_tag = 4'd1;
    mem2proc_data     = 64'h61;
    settle();
    check("t4_full_cmd_none", 64'(proc2mem_command), 64'(MEM_NONE));
    check("t4_full_addr_zero", 64'(proc2mem_addr), 64'd0);
    check("t4_full_r_ready", 64'(bus.r_req_ready), 64'd0);
    tick();
    mem2proc_data_tag = 4'd0;
    settle();
    check("t4_reopen_cmd", 64'(proc2mem_command), 64'(MEM_LOAD));
    check("t4_reopen_addr", 64'(proc2mem_addr), 64'h6200);
    check("t4_reopen_ready", 64'(bus.r_req_ready), 64'd1);
    check("t4_ret_rsp", 64'(bus.r_rsp_valid), 64'd1);
    tick();
    do_reset();

    // Out-of-order returns, then a stray tag.
    tick();
    bus.q_req_valid = 1'b1;
    bus.q_req_addr  = 32'h8000;
    mem2proc_transaction_tag = 4'd4;
    tick();
    bus.q_req_valid = 1'b0;
    bus.r_req_valid = 1'b1;
    bus.r_req_addr  = 32'h9000;
    mem2proc_transaction_tag = 4'd5;
    settle();
    check("t5_r_ready", 64'(bus.r_req_ready), 64'd1);
    tick();
    clear_inputs();
    mem2proc_data_tag = 4'd5;
    mem2proc_data     = 64'h55;
    tick();
    mem2proc_data_tag = 4'd4;
    mem2proc_data     = 64'h44;
    settle();
    check("t5_r_rsp_valid", 64'(bus.r_rsp_valid), 64'd1);
    check("t5_r_rsp_data", bus.r_rsp_data, 64'h55);
    check("t5_q_quiet", 64'(bus.q_rsp_valid), 64'd0);
    tick();
    mem2proc_data_tag = 4'd7;
    mem2proc_data     = 64'h77;
    settle();
    check("t5_q_rsp_valid", 64'(bus.q_rsp_valid), 64'd1);
    check("t5_q_rsp_data", bus.q_rsp_data, 64'h44);
    check("t5_r_done", 64'(bus.r_rsp_valid), 64'd0);
    check("t5_stray_not_yet", 64'(err_stray_tag), 64'd0);
    tick();
    clear_inputs();
    settle();
    check("t5_stray_q", 64'(bus.q_rsp_valid), 64'd0);
    check("t5_stray_r", 64'(bus.r_rsp_valid), 64'd0);
    check("t5_err_stray", 64'(err_stray_tag), 64'd1);
    check("t5_idle", 64'(idle), 64'd1);
    tick();
    do_reset();

    // Tag 6 returned (R) and re-issued to Q in the same cycle.
    tick();
    bus.r_req_valid = 1'b1;
    bus.r_req_addr  = 32'hA000;
    mem2proc_transaction_tag = 4'd6;
    tick();
    bus.r_req_valid = 1'b0;
    bus.q_req_valid = 1'b1;
    bus.q_req_addr  = 32'hB000;
    mem2proc_transaction_tag = 4'd6;
    mem2proc_data_tag = 4'd6;
    mem2proc_data     = 64'h66;
    settle();
    check("t6_q_ready", 64'(bus.q_req_ready), 64'd1);
    tick();
    clear_inputs();
    settle();
    check("t6_r_rsp_valid", 64'(bus.r_rsp_valid), 64'd1);
    check("t6_r_rsp_data", bus.r_rsp_data, 64'h66);
    check("t6_no_reuse_err", 64'(err_tag_reuse), 64'd0);
    check("t6_q_cnt", 64'(dut.q_cnt), 64'd1);
    check("t6_r_cnt", 64'(dut.r_cnt), 64'd0);
    tick();
    mem2proc_data_tag = 4'd6;
    mem2proc_data     = 64'h67;
    tick();
    clear_inputs();
    settle();
    check("t6_q_rsp_valid", 64'(bus.q_rsp_valid), 64'd1);
    check("t6_q_rsp_data", bus.q_rsp_data, 64'h67);
    check("t6_r_quiet", 64'(bus.r_rsp_valid), 64'd0);

    // Live tag reissued without a return: overwrite and flag.
    tick();
    bus.q_req_valid = 1'b1;
    bus.q_req_addr  = 32'hC000;
    mem2proc_transaction_tag = 4'd2;
    tick();
    bus.q_req_valid = 1'b0;
    bus.r_req_valid = 1'b1;
    bus.r_req_addr  = 32'hD000;
    mem2proc_transaction_tag = 4'd2;
    settle();
    check("t7_r_ready", 64'(bus.r_req_ready), 64'd1);
    tick();
    clear_inputs();
    settle();
    check("t7_err_reuse", 64'(err_tag_reuse), 64'd1);
    check("t7_q_cnt", 64'(dut.q_cnt), 64'd0);
    check("t7_r_cnt", 64'(dut.r_cnt), 64'd1);
    tick();
    mem2proc_data_tag = 4'd2;
    mem2proc_data     = 64'hD2;
    tick();
    clear_inputs();
    settle();
    check("t7_r_rsp_valid", 64'(bus.r_rsp_valid), 64'd1);
    check("t7_q_no_rsp", 64'(bus.q_rsp_valid), 64'd0);
    check("t7_r_rsp_data", bus.r_rsp_data, 64'hD2);
    check("t7_idle", 64'(idle), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_port_scheduler.md
Name: mem_port_scheduler

Overview:
- Shares the single memory port between three requesters: query load (Q), reference load (R) and result writeback store (W).
- Each cycle it issues at most one command and records the owner of every accepted load tag.
- Returned data is routed to the owning requester.
- Sits between the KNN memory controller FSM and the memory model; replaces direct proc2mem driving.

Parameters:
- MAX_OUTSTANDING, 8, maximum in-flight loads per load requester (Q, R); must be ≤ 15.
- NUM_TAGS, 16, size of the tag-owner table; index 0 is never a valid tag.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset (rst=0 resets)
- q_req_valid  in  1  query load request
- q_req_addr  in  ADDR  query load address
- q_req_ready  out  1  request accepted this cycle
- q_rsp_valid  out  1  query data valid
- q_rsp_data  out  MEM_BLOCK  query data
- r_req_valid  in  1  reference load request
- r_req_addr  in  ADDR  reference load address
- r_req_ready  out  1  request accepted this cycle
- r_rsp_valid  out  1  reference data valid
- r_rsp_data  out  MEM_BLOCK  reference data
- w_req_valid  in  1  writeback store request
- w_req_addr  in  ADDR  store address
- w_req_data  in  MEM_BLOCK  store data
- w_req_ready  out  1  store accepted this cycle
- mem2proc_transaction_tag  in  MEM_TAG  acceptance tag for this cycle's command; 0 = rejected
- mem2proc_data  in  MEM_BLOCK  load return data
- mem2proc_data_tag  in  MEM_TAG  tag of returned data; 0 = none
- proc2mem_command  out  MEM_COMMAND  NONE / MEM_LOAD / MEM_STORE
- proc2mem_addr  out  ADDR  command address
- proc2mem_data  out  MEM_BLOCK  store data
- idle  out  1  no load outstanding and no request pending
- err_stray_tag  out  1  sticky: returned tag had no owner
- err_tag_reuse  out  1  sticky: issued tag already owned

Behaviour:
- Reset (rst low, async):
  - tag table all invalid; both outstanding counters 0.
  - rsp_valid 0, rsp_data 0; error flags 0; idle 1.
  - proc2mem_command NONE, proc2mem_addr 0, proc2mem_data 0.
- Eligibility: W eligible when w_req_valid. Q or R eligible when its valid is high and its counter < MAX_OUTSTANDING.
- Grant: combinational, fixed priority W > Q > R, one grant per cycle. The granted request drives proc2mem_* in the same cycle. With no grant, the command is NONE and addr/data are 0.
- Acceptance:
  - granted *_req_ready = (mem2proc_transaction_tag != 0) in the same cycle; non-granted ready is 0.
  - Rejected (tag 0): nothing recorded; the requester holds valid/addr/data stable and retries.
- Accepted load: on the clock edge, table[tag] <= {valid=1, owner=Q|R} and that requester's counter increments.
- Accepted store: no table entry; no data return is expected.
- Return path:
  - If mem2proc_data_tag != 0 and table[tag].valid: registered, so the owner's rsp_valid=1 and rsp_data=mem2proc_data on the next cycle (1-cycle latency).
  - The entry is cleared and the owner's counter decrements.
  - rsp_valid is a one-cycle pulse per returned tag. Q and R never pulse in the same cycle.
- Stray tag (entry invalid): data dropped, err_stray_tag set.
- Same-cycle events:
  - Return and allocation of the same tag: free first, then allocate. The entry ends valid with the new owner; no error.
  - Return and accept for the same requester: counter unchanged.
  - Allocating a tag that is still valid (not freed this cycle): err_tag_reuse set, entry overwritten, old owner's counter decremented.
- Counters: width clog2(MAX_OUTSTANDING+1). They never underflow or overflow because eligibility blocks at full.
- idle = both counters 0 and no *_req_valid.
- Mid-operation reset: all in-flight tags are forgotten. Responses arriving after reset release flag err_stray_tag; the bench filters them.

Decomposition:
- Shared package global_defs: ADDR, MEM_BLOCK, MEM_TAG, MEM_COMMAND (already present).
- Add to the package: enum req_owner_e {OWN_Q, OWN_R} and struct tag_entry_t {logic valid; req_owner_e owner}.
- One sub-module: mem_tag_table. It holds NUM_TAGS entries, with an allocate port and a lookup/free port, and applies the free-before-allocate ordering.

Test Plan:
- Single Q load at 0x1000; memory tag 3, data 0xDEAD returns with tag 3 two cycles later. Expect q_req_ready 1 in the issue cycle, q_rsp_valid with data 0xDEAD one cycle after return, idle 1 afterward.
- W, Q, R all valid in the same cycle. Expect command sequence STORE, LOAD(Q addr), LOAD(R addr) on consecutive cycles with tags 1, 2, 3 all accepted.
- Memory returns tag 0 for 3 cycles on an R request. Expect r_req_ready 0 and the same address held for 3 cycles; accepted on cycle 4, counter 1.
- Issue 8 R loads with no returns. Expect the 9th R request blocked (command NONE) while a Q request is still granted; one return makes R eligible the next cycle.
- Data returns out of order with tags 5 (R) and 4 (Q). Expect r_rsp_valid then q_rsp_valid with matching data. A return with tag 7 (never issued) sets err_stray_tag and produces no rsp pulse.
- Tag 6 returned and re-issued to Q in the same cycle. Expect the old owner's response delivered, the entry owned by Q, and err_tag_reuse remaining 0.
